serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 cin  input  1  carry-in, captured when start is accepted.
REQ-008 sub  input  1  subtract select, captured when start is accepted; present only with SERIAL_ADDER_SUB_EN.
REQ-009 busy  output  1  high while bits are being processed.
REQ-010 done  output  1  one-cycle pulse when a new result is valid.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout  output  1  registered carry out of bit WIDTH-1.
REQ-013 overflow  output  1  registered signed overflow.

Function
REQ-014 The block SHALL compute the result bit-serially through one full-adder cell and one carry flip-flop, processing one bit per cycle, LSB first.
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 IDLE: start=1 -> capture a, b and cin into shift registers, load the carry flop with cin, clear the bit counter, go to SHIFT. start=0 -> stay in IDLE.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; each cycle adds the current LSBs plus the carry, shifts the sum bit in at the MSB of the result shift register, updates the carry, and increments the counter.
REQ-018 After the WIDTH-th SHIFT cycle, the FSM SHALL go to DONE and copy the result shift register, final carry and overflow into sum, cout and overflow.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency: with start accepted on the edge ending cycle 0, busy=1 in cycles 1..WIDTH, done=1 in cycle WIDTH+1, and start is accepted again from cycle WIDTH+2.
REQ-021 Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
REQ-022 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023 sum, cout and overflow SHALL change only on entry to DONE and SHALL hold their values until the next DONE.
REQ-024 start in SHIFT or DONE SHALL be ignored; it is not queued.
REQ-025 Changes on a, b, cin and sub after capture SHALL NOT affect the result in progress.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE and clear the following to 0: busy, done, sum, cout, overflow, the carry flop, the counter and the shift registers.
REQ-027 Reset during SHIFT or DONE SHALL abort the operation; done SHALL NOT pulse for the aborted operation.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro SERIAL_ADDER_SUB_EN defined: the sub port exists. With sub=1 captured, the block SHALL load ~b into the B shift register and force the initial carry to 1, ignoring cin. Result: sum = (a - b) mod 2^WIDTH; cout=1 means no borrow; overflow means signed subtraction overflow.
REQ-030 Macro SERIAL_ADDER_SUB_EN undefined: no sub port and no inversion logic; the block adds only.

Verification (WIDTH=8)
REQ-031 a=8'h0F, b=8'h01, cin=0, start pulse in cycle 0 -> busy high in cycles 1-8, done high in cycle 9 only, sum=8'h10, cout=0, overflow=0.
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0; a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, overflow=1.
REQ-033 Start a=8'h03, b=8'h04; in cycle 3 pulse start with a=8'hAA and b=8'h55 -> second start is ignored, single done pulse, sum=8'h07.
REQ-034 Start an operation; assert rst in cycle 4 -> busy=0 from cycle 5, sum=8'h00, and no done pulse; a new start in cycle 6 completes normally.
REQ-035 With SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, overflow=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1.

Source files
------------

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder. The sub select only exists when
// SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  // master issues requests and observes results; slave is the adder itself
  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and one carry flop, LSB first, WIDTH
// cycles per operation. Define SERIAL_ADDER_SUB_EN to add the subtract mode.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_if.slave      bus,
  output logic [1:0]         dbg_state
);

  // Handshake: start is only looked at in IDLE; accepting it latches a, b,
  // cin (and sub) in the same edge. busy is high for the WIDTH SHIFT cycles,
  // done pulses for exactly one cycle, and sum/cout/overflow update only on
  // that DONE entry and hold until the next one. start while busy/done is
  // dropped, never queued.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry_q;
    c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
    last_bit = (cnt == CW'(WIDTH - 1));
    res_next = {s_bit, res_sr[WIDTH-1:1]};
  end

`ifdef SERIAL_ADDER_SUB_EN
  // a - b is computed as a + ~b + 1, so subtraction reuses the same cell
  always_comb begin
    b_load = bus.sub ? ~bus.b : bus.b;
    c_load = bus.sub ? 1'b1   : bus.cin;
  end
`else
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      carry_q      <= 1'b0;
      cnt          <= '0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr    <= bus.a;
            b_sr    <= b_load;
            carry_q <= c_load;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          carry_q <= c_next;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB, c_next the carry out
            bus.sum      <= res_next;
            bus.cout     <= c_next;
            bus.overflow <= carry_q ^ c_next;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.busy  = (state == SHIFT);
    bus.done  = (state == DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised scoreboard bench for serial_adder with cycle-exact timing checks.
// Builds with or without SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_bad;
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: {cout, overflow, sum} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    longint ua, ub, sa, sb, full, r, lim;
    logic   co, ov;
    logic [W-1:0] s;
    lim = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - lim : ua;
    sb = b[W-1] ? ub - lim : ub;
    if (sub) begin
      full = ua - ub + lim;
      r    = sa - sb;
    end else begin
      full = ua + ub + longint'(cin);
      r    = sa + sb + longint'(cin);
    end
    s  = W'(full % lim);
    co = ((full / lim) % 2) == 1;
    ov = (r > (lim / 2) - 1) || (r < -(lim / 2));
    return {co, ov, s};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum",      32'(bus.sum),      32'(e[W-1:0]));
        check("overflow", 32'(bus.overflow), 32'(e[W]));
        check("cout",     32'(bus.cout),     32'(e[W+1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: sub requested without subtract build");
`endif
  endtask

  // Issues one operation in "cycle 0" and checks busy/done timing. ign_at>0
  // pulses a stray start (with other operands) in that cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int ign_at);
    logic [W+1:0] e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    set_sub(sub);
    e = model(a, b, cin, sub);
    exp_q.push_back(e);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      bus.start = (i == ign_at);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      set_sub(1'($urandom));
`endif
      check($sformatf("busy_c%0d", i), 32'(bus.busy), 32'd1);
      check($sformatf("nodone_c%0d", i), 32'(bus.done), 32'd0);
      check("sum_hold", 32'(bus.sum), 32'(last_sum));
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    last_sum = e[W-1:0];
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_again", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks  = 0;
    n_bad     = 0;
    last_sum  = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    set_sub(1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf",  32'(bus.overflow), 32'd0);
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, 0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 3);

    // abort mid-operation: rst sampled at the edge ending cycle 4
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h66;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    last_sum = '0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sum",  32'(bus.sum),  32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    run_op(8'h21, 8'h12, 1'b1, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic s;
      s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), s,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0);
    end

    repeat (W + 4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
